// File: rtl/subband_serializer_pkg.sv
// ============================================================================
// Module      : subband_serializer_pkg
// Description : Shared filterbank constants and read-FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package subband_serializer_pkg;

  localparam int C_NUM_BANDS = 16;
  localparam int C_DATA_W    = 27;
  localparam int C_DROP_W    = 8;
  localparam int C_CHAN_W    = 4;

  typedef enum logic [0:0] {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/fb_frame_bank.sv
// ============================================================================
// Module      : fb_frame_bank
// Description : One frame of channel samples; all channels written at once,
//               one channel read combinationally by index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_frame_bank
  import subband_serializer_pkg::*;
#(
  parameter int NUM_BANDS = C_NUM_BANDS,
  parameter int DATA_W    = C_DATA_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en_i,
  input  logic [NUM_BANDS*DATA_W-1:0] wr_data_i,
  input  logic [C_CHAN_W-1:0]         rd_idx_i,
  output logic [DATA_W-1:0]           rd_data_o
);

  logic [DATA_W-1:0] mem_q [NUM_BANDS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_BANDS; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      for (int i = 0; i < NUM_BANDS; i++) mem_q[i] <= wr_data_i[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (rd_idx_i == C_CHAN_W'(i)) rd_data_o = mem_q[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/subband_serializer.sv
// ============================================================================
// Module      : subband_serializer
// Description : Ping-pong frame capture of filterbank outputs, serialized as a
//               valid/ready channel stream with overflow accounting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module subband_serializer
  import subband_serializer_pkg::*;
#(
  parameter int NUM_BANDS = C_NUM_BANDS,
  parameter int DATA_W    = C_DATA_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clk_enable,
  input  logic                        phase_52,
  input  logic [NUM_BANDS*DATA_W-1:0] band_in,
  output logic [DATA_W-1:0]           out_data,
  output logic [C_CHAN_W-1:0]         out_chan,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_sof,
  output logic                        out_eof,
  output logic                        overflow,
  output logic [C_DROP_W-1:0]         drop_cnt
);

  localparam logic [C_CHAN_W-1:0] LAST_CHAN = C_CHAN_W'(NUM_BANDS - 1);

  rd_state_e             state_q, state_d;
  logic [C_CHAN_W-1:0]   chan_q, chan_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            full_q, full_d;
  logic                  overflow_q, overflow_d;
  logic [C_DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic                  w_cap, w_beat, w_last, w_wr_en, w_wr_sel, w_drop;
  logic [DATA_W-1:0]     w_bank_rd [2];

  generate
    for (genvar gb = 0; gb < 2; gb++) begin : g_bank
      fb_frame_bank #(
        .NUM_BANDS (NUM_BANDS),
        .DATA_W    (DATA_W)
      ) u_bank (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (w_wr_en && (w_wr_sel == gb[0])),
        .wr_data_i (band_in),
        .rd_idx_i  (chan_q),
        .rd_data_o (w_bank_rd[gb])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RD_IDLE;
      chan_q     <= '0;
      rd_ptr_q   <= 1'b0;
      full_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    w_cap    = clk_enable & phase_52;
    w_beat   = clk_enable & (state_q == RD_DRAIN) & out_ready;
    w_last   = w_beat & (chan_q == LAST_CHAN);
    w_wr_en  = 1'b0;
    w_wr_sel = rd_ptr_q;
    w_drop   = 1'b0;

    // While draining, prefer the idle bank; fall back to the bank freed this edge.
    if (w_cap) begin
      if (state_q == RD_IDLE) begin
        w_wr_en = 1'b1;
      end else if (!full_q[~rd_ptr_q]) begin
        w_wr_en  = 1'b1;
        w_wr_sel = ~rd_ptr_q;
      end else if (w_last) begin
        w_wr_en = 1'b1;
      end else begin
        w_drop = 1'b1;
      end
    end

    full_d = full_q;
    if (w_last)  full_d[rd_ptr_q] = 1'b0;
    if (w_wr_en) full_d[w_wr_sel] = 1'b1;

    rd_ptr_d = rd_ptr_q ^ w_last;

    chan_d = chan_q;
    if (w_last)      chan_d = '0;
    else if (w_beat) chan_d = chan_q + C_CHAN_W'(1);

    state_d = full_d[rd_ptr_d] ? RD_DRAIN : RD_IDLE;

    overflow_d = overflow_q | w_drop;
    drop_cnt_d = drop_cnt_q;
    if (w_drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + C_DROP_W'(1);
  end

  assign out_valid = (state_q == RD_DRAIN);
  assign out_chan  = chan_q;
  assign out_data  = w_bank_rd[rd_ptr_q];
  assign out_sof   = out_valid && (chan_q == '0);
  assign out_eof   = out_valid && (chan_q == LAST_CHAN);
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_subband_serializer.sv
// ============================================================================
// Module      : tb_subband_serializer
// Description : Scoreboard bench for subband_serializer with directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_subband_serializer;

  localparam int NB = 16;
  localparam int DW = 27;

  logic             clock = 1'b0;
  logic             reset;
  logic             clk_enable;
  logic             phase_52;
  logic [NB*DW-1:0] band_in;
  logic [DW-1:0]    out_data;
  logic [3:0]       out_chan;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_eof;
  logic             overflow;
  logic [7:0]       drop_cnt;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [3:0]    chan;
    logic          sof;
    logic          eof;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  subband_serializer #(.NUM_BANDS(NB), .DATA_W(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .clk_enable (clk_enable),
    .phase_52   (phase_52),
    .band_in    (band_in),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clock = ~clock;

  // Frame 3 carries the most negative and most positive 27-bit values.
  function automatic logic [DW-1:0] fv(int fid, int i);
    longint v;
    if (fid == 1)                   v = longint'(i) * 1000 - 8000;
    else if (fid == 3 && i == 0)    v = -67108864;
    else if (fid == 3 && i == 15)   v = 67108863;
    else if (i % 2 == 1)            v = -(longint'(fid) * 100003 + longint'(i) * 7919);
    else                            v = longint'(fid) * 100003 + longint'(i) * 7919;
    return v[DW-1:0];
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(int fid);
    for (int i = 0; i < NB; i++) band_in[i*DW +: DW] = fv(fid, i);
  endtask

  task automatic capture(int fid, bit accept);
    load(fid);
    phase_52 = 1'b1;
    if (accept) begin
      for (int i = 0; i < NB; i++)
        sb.push_back('{data: fv(fid, i), chan: 4'(i), sof: (i == 0), eof: (i == NB - 1)});
    end
    tick();
    phase_52 = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    clk_enable = 1'b1;
    load(14);
    phase_52   = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    phase_52 = 1'b0;
    sb.delete();
  endtask

  task automatic wait_drain(int budget);
    for (int n = 0; n < budget; n++) begin
      if (sb.size() == 0 && !out_valid) break;
      tick();
    end
    chk("drain_done", longint'(sb.size() == 0 && !out_valid), 1);
  endtask

  always @(negedge clock) begin
    if (!reset && clk_enable && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got chan %0d data %0d, expected no beat", out_chan, out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("beat_data", longint'(out_data), longint'(mon_e.data));
        chk("beat_chan", longint'(out_chan), longint'(mon_e.chan));
        chk("beat_sof",  longint'(out_sof),  longint'(mon_e.sof));
        chk("beat_eof",  longint'(out_eof),  longint'(mon_e.eof));
      end
    end
  end

  initial begin
    bit pat [4];
    int exp_ch;
    pat        = '{1'b1, 1'b0, 1'b0, 1'b1};
    reset      = 1'b1;
    clk_enable = 1'b1;
    phase_52   = 1'b0;
    out_ready  = 1'b0;
    band_in    = '0;

    // Reset state, with a strobe held during reset
    do_reset();
    chk("rst_valid",    longint'(out_valid), 0);
    chk("rst_sof",      longint'(out_sof),   0);
    chk("rst_eof",      longint'(out_eof),   0);
    chk("rst_chan",     longint'(out_chan),  0);
    chk("rst_data",     longint'(out_data),  0);
    chk("rst_overflow", longint'(overflow),  0);
    chk("rst_drop",     longint'(drop_cnt),  0);
    tick();
    chk("rst_no_capture", longint'(out_valid), 0);

    // Single frame, out_ready held high
    out_ready = 1'b1;
    capture(1, 1'b1);
    chk("lat_valid", longint'(out_valid), 1);
    chk("lat_chan",  longint'(out_chan),  0);
    chk("lat_sof",   longint'(out_sof),   1);
    wait_drain(40);

    // Backpressure pattern 1,0,0,1
    out_ready = 1'b0;
    capture(2, 1'b1);
    tick();
    tick();
    chk("stall_chan", longint'(out_chan), 0);
    chk("stall_data", longint'(out_data), longint'(fv(2, 0)));
    exp_ch = 0;
    for (int n = 0; n < 80 && exp_ch < NB; n++) begin
      out_ready = pat[n % 4];
      tick();
      if (out_ready) exp_ch++;
      if (exp_ch < NB) begin
        chk("bp_chan", longint'(out_chan), longint'(exp_ch));
        chk("bp_data", longint'(out_data), longint'(fv(2, exp_ch)));
        chk("bp_valid", longint'(out_valid), 1);
      end
    end
    out_ready = 1'b1;
    wait_drain(10);

    // Overflow: third frame dropped while both banks are full
    out_ready = 1'b0;
    capture(3, 1'b1);
    tick();
    capture(4, 1'b1);
    tick();
    capture(5, 1'b0);
    chk("ovf_flag", longint'(overflow), 1);
    chk("ovf_drop", longint'(drop_cnt), 1);
    chk("ovf_data_hold", longint'(out_data), longint'(fv(3, 0)));
    out_ready = 1'b1;
    wait_drain(60);
    chk("ovf_sticky", longint'(overflow), 1);

    // Capture coincident with final beat while both banks full
    do_reset();
    out_ready = 1'b0;
    capture(6, 1'b1);
    capture(7, 1'b1);
    out_ready = 1'b1;
    repeat (15) tick();
    chk("sim_chan15", longint'(out_chan), 15);
    capture(8, 1'b1);
    chk("sim_overflow", longint'(overflow), 0);
    chk("sim_drop",     longint'(drop_cnt), 0);
    wait_drain(60);

    // clk_enable low mid-drain freezes everything
    out_ready = 1'b1;
    capture(9, 1'b1);
    repeat (3) tick();
    clk_enable = 1'b0;
    load(10);
    phase_52 = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("ce_chan",  longint'(out_chan),  3);
      chk("ce_valid", longint'(out_valid), 1);
      chk("ce_data",  longint'(out_data),  longint'(fv(9, 3)));
    end
    clk_enable = 1'b1;
    phase_52   = 1'b0;
    wait_drain(40);

    // Reset mid-drain with second bank full and a drop recorded
    out_ready = 1'b0;
    capture(11, 1'b1);
    capture(12, 1'b1);
    capture(14, 1'b0);
    chk("pre_rst_drop", longint'(drop_cnt), 1);
    out_ready = 1'b1;
    repeat (7) tick();
    chk("pre_rst_chan", longint'(out_chan), 7);
    reset    = 1'b1;
    load(13);
    phase_52 = 1'b1;
    tick();
    reset    = 1'b0;
    phase_52 = 1'b0;
    sb.delete();
    chk("mid_rst_valid",    longint'(out_valid), 0);
    chk("mid_rst_drop",     longint'(drop_cnt),  0);
    chk("mid_rst_overflow", longint'(overflow),  0);
    chk("mid_rst_data",     longint'(out_data),  0);
    tick();
    chk("mid_rst_idle", longint'(out_valid), 0);
    capture(13, 1'b1);
    chk("post_rst_chan", longint'(out_chan), 0);
    wait_drain(40);

    // Drop counter saturation
    do_reset();
    out_ready = 1'b0;
    capture(15, 1'b1);
    capture(4, 1'b1);
    load(10);
    phase_52 = 1'b1;
    repeat (258) tick();
    phase_52 = 1'b0;
    chk("sat_drop",     longint'(drop_cnt), 255);
    chk("sat_overflow", longint'(overflow), 1);
    out_ready = 1'b1;
    wait_drain(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
